// File: rtl/reg_file_reader_if.sv
// reg_file_reader_if
//   Command and read-data handshake bundle for reg_file_reader.
//   Optional signal: rd_parity, present only when READER_PARITY_EN is defined.
//
//   Signals:
//     req_valid / req_ready  command handshake
//     req_addr, req_burst    first register index, single (0) or 4-beat burst (1)
//     rd_valid / rd_ready    data beat handshake
//     rd_data, rd_addr       register value and its index
//     rd_last                final beat of the current command
//     rd_parity              even parity of rd_data (READER_PARITY_EN only)
//
//   Modports:
//     master  requester/consumer side (drives command and rd_ready)
//     slave   the reader itself
interface reg_file_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic       req_burst;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [1:0] rd_addr;
    logic       rd_last;
`ifdef READER_PARITY_EN
    logic       rd_parity;
`endif

    modport master (
        output req_valid,
        input  req_ready,
        output req_addr,
        output req_burst,
        input  rd_valid,
        output rd_ready,
        input  rd_data,
        input  rd_addr,
`ifdef READER_PARITY_EN
        input  rd_parity,
`endif
        input  rd_last
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_addr,
        input  req_burst,
        output rd_valid,
        input  rd_ready,
        output rd_data,
        output rd_addr,
`ifdef READER_PARITY_EN
        output rd_parity,
`endif
        output rd_last
    );
endinterface

// File: rtl/reg_file_reader.sv
// reg_file_reader
//   Read-side sequencer for the 4 x 8-bit register bank. Accepts single or
//   4-beat burst read commands and streams registered snapshots of the bank
//   contents; each beat is sampled at the edge that launches it and held
//   stable while the consumer stalls.
//   Optional feature: READER_PARITY_EN adds a registered rd_parity output.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-high
//     reg0..reg3 live register bank contents
//     bus        reg_file_reader_if.slave (command and read-data handshakes)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no beat outstanding; req_ready high, waiting for a command
//   SEND  | a beat is presented on rd_*; waiting for the consumer handshake
module reg_file_reader (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         reg0,
    input  logic [7:0]         reg1,
    input  logic [7:0]         reg2,
    input  logic [7:0]         reg3,
    reg_file_reader_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state, state_nxt;

    logic [1:0] beat_cnt, beat_cnt_nxt;
    logic       valid_q, valid_nxt;
    logic [7:0] data_q, data_nxt;
    logic [1:0] addr_q, addr_nxt;
    logic       last_q, last_nxt;
    logic [1:0] next_idx;

    // Bank select, used only to load the output register.
    function automatic logic [7:0] bank_sel(input logic [1:0] idx,
                                            input logic [7:0] r0,
                                            input logic [7:0] r1,
                                            input logic [7:0] r2,
                                            input logic [7:0] r3);
        logic [7:0] v;
        case (idx)
            2'd0:    v = r0;
            2'd1:    v = r1;
            2'd2:    v = r2;
            default: v = r3;
        endcase
        return v;
    endfunction

    // 2-bit add wraps index 3 back to 0 naturally.
    assign next_idx = addr_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= 2'd0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            addr_q   <= 2'd0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            valid_q  <= valid_nxt;
            data_q   <= data_nxt;
            addr_q   <= addr_nxt;
            last_q   <= last_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        valid_nxt    = valid_q;
        data_nxt     = data_q;
        addr_nxt     = addr_q;
        last_nxt     = last_q;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    data_nxt     = bank_sel(bus.req_addr, reg0, reg1, reg2, reg3);
                    addr_nxt     = bus.req_addr;
                    beat_cnt_nxt = bus.req_burst ? 2'd3 : 2'd0;
                    last_nxt     = ~bus.req_burst;
                    valid_nxt    = 1'b1;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (bus.rd_ready) begin
                    if (beat_cnt != 2'd0) begin
                        data_nxt     = bank_sel(next_idx, reg0, reg1, reg2, reg3);
                        addr_nxt     = next_idx;
                        beat_cnt_nxt = beat_cnt - 2'd1;
                        last_nxt     = (beat_cnt == 2'd1);
                    end else begin
                        // Data and address keep the final beat's values.
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rd_valid  = valid_q;
    assign bus.rd_data   = data_q;
    assign bus.rd_addr   = addr_q;
    assign bus.rd_last   = last_q;

`ifdef READER_PARITY_EN
    logic parity_q;

    // Registered from the same next-value as rd_data so both change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ^data_nxt;
    end

    assign bus.rd_parity = parity_q;
`endif

endmodule

// File: tb/tb_reg_file_reader.sv
// tb_reg_file_reader
//   Self-checking bench for reg_file_reader. A transaction-level model keeps
//   a queue of register indices still owed for the current command and
//   samples the bank whenever a beat is launched.
module tb_reg_file_reader;

    logic       clk;
    logic       reset;
    logic [7:0] bank [4];

    reg_file_reader_if bus ();

    reg_file_reader dut (
        .clk   (clk),
        .reset (reset),
        .reg0  (bank[0]),
        .reg1  (bank[1]),
        .reg2  (bank[2]),
        .reg3  (bank[3]),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit         m_busy;
    int         m_q[$];
    logic [7:0] m_data;
    logic [1:0] m_addr;

`ifdef READER_PARITY_EN
    localparam int VW = 14;
    wire [VW-1:0] dut_vec = {bus.rd_valid, bus.req_ready, bus.rd_data,
                             bus.rd_addr, bus.rd_last, bus.rd_parity};
`else
    localparam int VW = 13;
    wire [VW-1:0] dut_vec = {bus.rd_valid, bus.req_ready, bus.rd_data,
                             bus.rd_addr, bus.rd_last};
`endif

    function automatic logic [VW-1:0] exp_vec();
        logic m_last;
        m_last = m_busy && (m_q.size() == 1);
`ifdef READER_PARITY_EN
        return {m_busy, ~m_busy, m_data, m_addr, m_last, ^m_data};
`else
        return {m_busy, ~m_busy, m_data, m_addr, m_last};
`endif
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_q    = {};
        m_data = 8'h00;
        m_addr = 2'd0;
    endtask

    // Apply one rising edge to the model using the inputs present now.
    task automatic model_edge();
        int n;
        if (!m_busy) begin
            if (bus.req_valid) begin
                n = bus.req_burst ? 4 : 1;
                m_q = {};
                for (int i = 0; i < n; i++) m_q.push_back((int'(bus.req_addr) + i) % 4);
                m_busy = 1'b1;
                m_addr = 2'(m_q[0]);
                m_data = bank[m_q[0]];
            end
        end else if (bus.rd_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_busy = 1'b0;
            end else begin
                m_addr = 2'(m_q[0]);
                m_data = bank[m_q[0]];
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr  = 2'd0;
        bus.req_burst = 1'b0;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int i = 0; i < 4; i++) bank[i] = 8'h00;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (dut_vec !== {1'b0, 1'b1, 8'h00, 2'd0, 1'b0
`ifdef READER_PARITY_EN
                         , 1'b0
`endif
                         }) begin
            n_fail++;
            $display("FAIL reset_values got %h expected valid0 ready1 data00 addr0 last0", dut_vec);
        end
    endtask

    task automatic test_single();
        bank[2] = 8'hA5;
        bus.req_valid = 1'b1; bus.req_addr = 2'd2; bus.req_burst = 1'b0; bus.rd_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        n_tests++;
        if ({bus.rd_valid, bus.rd_data, bus.rd_addr, bus.rd_last, bus.req_ready} !== {1'b1, 8'hA5, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_beat got v%b d%h a%0d l%b r%b expected v1 dA5 a2 l1 r0",
                     bus.rd_valid, bus.rd_data, bus.rd_addr, bus.rd_last, bus.req_ready);
        end
        step();
        n_tests++;
        if ({bus.rd_valid, bus.rd_last, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_done got v%b l%b r%b expected v0 l0 r1",
                     bus.rd_valid, bus.rd_last, bus.req_ready);
        end
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_model got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] exp_d [4];
        logic [1:0] exp_a [4];
        exp_d[0] = 8'h30; exp_d[1] = 8'h40; exp_d[2] = 8'h10; exp_d[3] = 8'h20;
        exp_a[0] = 2'd2;  exp_a[1] = 2'd3;  exp_a[2] = 2'd0;  exp_a[3] = 2'd1;
        bank[0] = 8'h10; bank[1] = 8'h20; bank[2] = 8'h30; bank[3] = 8'h40;
        bus.req_valid = 1'b1; bus.req_addr = 2'd2; bus.req_burst = 1'b1; bus.rd_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if ({bus.rd_valid, bus.rd_data, bus.rd_addr, bus.rd_last} !== {1'b1, exp_d[b], exp_a[b], (b == 3)}) begin
                n_fail++;
                $display("FAIL burst_wrap beat%0d got v%b d%h a%0d l%b expected v1 d%h a%0d l%b",
                         b, bus.rd_valid, bus.rd_data, bus.rd_addr, bus.rd_last, exp_d[b], exp_a[b], (b == 3));
            end
            step();
        end
        n_tests++;
        if (dut_vec !== exp_vec() || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_stall_snapshot();
        bank[1] = 8'h55;
        bus.req_valid = 1'b1; bus.req_addr = 2'd1; bus.req_burst = 1'b0; bus.rd_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bank[1] = 8'hAA;
            step();
            n_tests++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h55} || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall_hold cycle%0d got v%b d%h expected v1 d55", c, bus.rd_valid, bus.rd_data);
            end
        end
        bus.rd_ready = 1'b1;
        step();
        n_tests++;
        if (bus.rd_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall_release got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_mid_burst_stall();
        int beats;
        for (int i = 0; i < 4; i++) bank[i] = 8'(8'h61 + i);
        bus.req_valid = 1'b1; bus.req_addr = 2'd0; bus.req_burst = 1'b1; bus.rd_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        beats = 1;
        step();
        beats++;
        bus.rd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bank[1] = 8'(8'hC0 + c);
            bank[2] = 8'(8'hD0 + c);
            step();
            n_tests++;
            if (dut_vec !== exp_vec() || bus.rd_data !== 8'h62) begin
                n_fail++;
                $display("FAIL mid_stall cycle%0d got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.rd_valid === 1'b1 && c > 0) beats++;
            step();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL mid_resume cycle%0d got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (beats !== 4) begin
            n_fail++;
            $display("FAIL mid_beat_count got %0d expected 4", beats);
        end
    endtask

    task automatic test_back_pressure();
        int accept_cycle;
        int last_cycle;
        accept_cycle = -1;
        last_cycle   = -1;
        bus.req_valid = 1'b1; bus.req_addr = 2'd3; bus.req_burst = 1'b1; bus.rd_ready = 1'b1;
        step();
        for (int c = 0; c < 8; c++) begin
            if (bus.rd_valid && bus.rd_last && last_cycle < 0) last_cycle = c;
            if (bus.req_ready && accept_cycle < 0 && last_cycle >= 0) accept_cycle = c;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_pressure cycle%0d got %h expected %h", c, dut_vec, exp_vec());
            end
            step();
        end
        bus.req_valid = 1'b0;
        n_tests++;
        if (accept_cycle !== last_cycle + 1) begin
            n_fail++;
            $display("FAIL back_pressure_spacing got accept@%0d expected %0d", accept_cycle, last_cycle + 1);
        end
        while (m_busy) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bank[$urandom_range(0, 3)] = 8'($urandom);
            if (!(bus.req_valid && !m_busy)) begin
                bus.req_valid = ($urandom_range(0, 2) != 0);
                bus.req_addr  = 2'($urandom);
                bus.req_burst = 1'($urandom);
            end
            bus.rd_ready = ($urandom_range(0, 3) != 0);
            step();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle%0d got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        idle_inputs();
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 4; i++) bank[i] = 8'(8'h13 + 8'h22 * i);
        bus.req_valid = 1'b1; bus.req_addr = 2'd0; bus.req_burst = 1'b1; bus.rd_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({bus.rd_valid, bus.rd_last, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid_burst got v%b l%b r%b expected v0 l0 r1",
                     bus.rd_valid, bus.rd_last, bus.req_ready);
        end
`ifdef READER_PARITY_EN
        n_tests++;
        if (bus.rd_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_parity got %b expected 0", bus.rd_parity);
        end
`endif
        #2;
        reset = 1'b0;
        bank[3] = 8'h07;
        bus.req_valid = 1'b1; bus.req_addr = 2'd3; bus.req_burst = 1'b0; bus.rd_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        n_tests++;
        if ({bus.rd_valid, bus.rd_data, bus.rd_last} !== {1'b1, 8'h07, 1'b1} || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset_read got v%b d%h l%b expected v1 d07 l1",
                     bus.rd_valid, bus.rd_data, bus.rd_last);
        end
`ifdef READER_PARITY_EN
        n_tests++;
        if (bus.rd_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_parity got %b expected 1", bus.rd_parity);
        end
`endif
        bus.rd_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_stall_snapshot();
        test_mid_burst_stall();
        test_back_pressure();
        test_random();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_reader.md
# reg_file_reader

Read-side sequencer for the 4 x 8-bit general register bank. Accepts single-register or 4-beat burst read requests over a valid/ready command port and returns register contents over a valid/ready data port. Each returned byte is a snapshot that stays stable while the port is stalled. It connects directly to the bank's four parallel outputs and lets a downstream consumer (UART, bus bridge, debug port) stream register state without a combinational mux path.

## Interface
Parameters:
- none (bank width 8, depth 4 fixed)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- reg0, reg1, reg2, reg3  in  8 each  live register bank contents
- req_valid  in  1  read command present
- req_ready  out  1  command accepted when req_valid && req_ready
- req_addr  in  2  first register index
- req_burst  in  1  0 = single beat, 1 = four beats
- rd_valid  out  1  data beat present
- rd_ready  in  1  consumer accepts beat when rd_valid && rd_ready
- rd_data  out  8  register value
- rd_addr  out  2  index of register in rd_data
- rd_last  out  1  final beat of the current command
- rd_parity  out  1  even parity of rd_data (present only with READER_PARITY_EN)

## Operation
- FSM states: IDLE, SEND.
- req_ready = (state == IDLE), decoded from state (not registered).
- IDLE, command handshake: capture reg[req_addr] into rd_data and req_addr into rd_addr. Load beat counter: 0 for single, 3 for burst. Set rd_last = (counter == 0). Set rd_valid = 1. Go to SEND.
- SEND, beat handshake with counter != 0:
  - next index = rd_addr + 1, mod 4 (3 wraps to 0)
  - rd_data <= reg[next index] sampled at that edge; rd_addr <= next index
  - counter decrements; rd_last <= (new counter == 0); rd_valid stays 1
- SEND, beat handshake with counter == 0: rd_valid <= 0, rd_last <= 0, return to IDLE. rd_data and rd_addr hold their values.
- SEND without handshake: all rd_* outputs hold. Bank changes after capture are not reflected.
- Commands presented while in SEND are not accepted (req_ready = 0). The requester must hold req_valid.
- rd_valid, once asserted, does not deassert until the handshake.
- Reset mid-burst: remaining beats are discarded with no partial completion. State returns to IDLE.

## Timing
- Reset values: rd_valid 0, rd_data 0x00, rd_addr 0, rd_last 0, rd_parity 0, counter 0, state IDLE (req_ready 1).
- Command-to-first-beat latency: 1 cycle (rd_valid high the cycle after the command handshake).
- Burst throughput: 1 beat per cycle while rd_ready is held high. An unstalled burst occupies 4 SEND cycles.
- Command spacing: a new command is accepted no earlier than 1 cycle after the last-beat handshake. An unstalled single read occupies 2 cycles per command.
- Register sampling: each beat's value is taken at the edge that launches that beat (command handshake, or the previous beat's handshake).

## Configuration
- READER_PARITY_EN defined: adds rd_parity output = XOR of rd_data bits, registered alongside rd_data and held with it.
- READER_PARITY_EN undefined: rd_parity port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then single read: reg2=0xA5, req_addr=2, req_burst=0, rd_ready=1 -> next cycle rd_valid=1, rd_data=0xA5, rd_addr=2, rd_last=1; rd_valid=0 the cycle after; req_ready returns to 1.
- Burst with wrap: reg0..3 = 0x10,0x20,0x30,0x40, req_addr=2, burst, rd_ready=1 -> beats 0x30/2, 0x40/3, 0x10/0, 0x20/1 on consecutive cycles; rd_last only on 0x20.
- Stall with snapshot: single read of reg1=0x55, rd_ready=0 for 5 cycles, reg1 changes to 0xAA during the stall -> rd_data holds 0x55 and rd_valid holds 1; beat completes when rd_ready=1.
- Mid-burst stall: burst from addr 0, rd_ready low after beat 1 for 3 cycles, reg1 changed during the stall -> beat 2 carries reg1 as sampled at beat 1's handshake; no beats are lost or duplicated.
- Back-pressure on command: req_valid held during a burst -> req_ready=0 throughout SEND; the second command is accepted exactly 1 cycle after the last-beat handshake.
- Reset mid-burst (with READER_PARITY_EN): assert reset after beat 1 -> rd_valid, rd_last, rd_parity=0 immediately, req_ready=1. Then a single read of 0x07 gives rd_parity=1.
